// File: rtl/nios_accelerometer_switch_debounce.sv
// Switch-input front end for the 10-bit slide-switch PIO.
// Synchronises raw switch levels, debounces each bit against a shared
// prescaled tick, and drives the clean level vector to the PIO in_port.
// A small Avalon-MM slave exposes the levels, a per-bit change-capture
// register (write-1-to-clear) and an interrupt mask.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   sw_raw      raw (asynchronous) switch levels
//   sw_out      debounced switch levels
//   address     Avalon-MM word address (0 levels, 1 reserved, 2 mask, 3 edge capture)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, valid 1 clk after the address
//   irq         level interrupt, |(edge_cap & irq_mask) registered
module nios_accelerometer_switch_debounce #(
  parameter int unsigned WIDTH        = 10,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  localparam logic [1:0] ADDR_LEVEL = 2'd0;
  localparam logic [1:0] ADDR_RSVD  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [PW-1:0]    presc;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] irq_mask;

  logic             tick_c;
  logic             wr_c;
  logic [WIDTH-1:0] chg_c;
  logic [WIDTH-1:0] clr_c;
  logic [31:0]      rd_c;
  logic             unused_wdata_c;

  // Two-flop synchroniser; only sync2 feeds the debouncers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Free-running prescaler; tick marks its last count.
  assign tick_c = (presc == TICK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (tick_c) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // A bit is accepted on the tick that completes STABLE_TICKS mismatching ticks.
  always_comb begin
    chg_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (tick_c && (sync2[i] != sw_out[i]) && (cnt[i] == CNT_LAST)) begin
        chg_c[i] = 1'b1;
      end
    end
  end

  // Per-bit debounce counters; any return to the accepted level restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_out <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2[i] == sw_out[i]) begin
          cnt[i] <= '0;
        end else if (chg_c[i]) begin
          sw_out[i] <= sync2[i];
          cnt[i]    <= '0;
        end else if (tick_c) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Bus write decode.
  assign wr_c  = chipselect & ~write_n;
  assign clr_c = (wr_c && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  // Only the low WIDTH bits of writedata carry register content.
  assign unused_wdata_c = ^writedata;

  // Edge capture (set beats clear), interrupt mask and interrupt line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      edge_cap <= (edge_cap & ~clr_c) | chg_c;
      if (wr_c && (address == ADDR_MASK)) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      irq <= |(edge_cap & irq_mask);
    end
  end

  // Read mux, registered every cycle independent of chipselect.
  always_comb begin
    rd_c = '0;
    case (address)
      ADDR_LEVEL: rd_c = 32'(sw_out);
      ADDR_RSVD:  rd_c = '0;
      ADDR_MASK:  rd_c = 32'(irq_mask);
      ADDR_EDGE:  rd_c = 32'(edge_cap);
      default:    rd_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_c;
    end
  end

endmodule
